// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port RAM shared by the VGA read path (one slot per pixel) and a pixel writer.
// Optional statistics outputs (frame_cnt, wr_stall_cnt) are enabled by defining VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 17,
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int SCALE_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pclk_tick,
    input  logic              de,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              sync_err
`ifdef VGA_FB_ARB_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       wr_stall_cnt
`endif
);

    localparam int STAGES = 1;
    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

    typedef enum logic {SYNC, RUN} state_t;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } fb_req_t;

    state_t            state;
    logic [1:0]        phase;
    logic              de_q;
    logic              de_d2;
    logic [ADDR_W-1:0] rd_addr;
    logic [STAGES:0]   vld_pipe;   // [0]: display slot cycle, [1]: read data cycle
    logic [31:0]       rd_addr_full;
    logic              disp_slot;
    logic              wr_fire;
    fb_req_t           req;

    assign rd_addr_full = 32'(y_pixel >> SCALE_SHIFT) * 32'(FB_W) + 32'(x_pixel >> SCALE_SHIFT);

    assign disp_slot = (state == RUN) && vld_pipe[0] && de_q;
    assign wr_ready  = !reset && !disp_slot;
    assign wr_fire   = wr_valid && wr_ready;

    always_comb begin
        req = '0;
        if (reset) begin
            req = '0;
        end else if (disp_slot) begin
            req.en   = 1'b1;
            req.addr = rd_addr;
        end else if (wr_fire && ({1'b0, wr_addr} < FB_SIZE)) begin
            // out-of-range writes are accepted but never reach the RAM
            req.en    = 1'b1;
            req.we    = 1'b1;
            req.addr  = wr_addr;
            req.wdata = wr_data;
        end
    end

    assign mem_en    = req.en;
    assign mem_we    = req.we;
    assign mem_addr  = req.addr;
    assign mem_wdata = req.wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            phase     <= 2'd0;
            sync_err  <= 1'b0;
            de_q      <= 1'b0;
            de_d2     <= 1'b0;
            rd_addr   <= '0;
            vld_pipe  <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], pclk_tick};
            de_d2    <= de_q;
            if (pclk_tick) begin
                de_q    <= de;
                rd_addr <= rd_addr_full[ADDR_W-1:0];
            end
            case (state)
                SYNC: begin
                    if (pclk_tick) begin
                        state <= RUN;
                        phase <= 2'd0;
                    end
                end
                RUN: begin
                    if (pclk_tick) begin
                        if (phase != 2'd3) sync_err <= 1'b1;
                        phase <= 2'd0;
                    end else if (phase != 2'd3) begin
                        phase <= phase + 2'd1;
                    end
                end
                default: state <= SYNC;
            endcase
            if (vld_pipe[STAGES]) begin
                pix_valid <= de_d2;
                pix_data  <= de_d2 ? mem_rdata : '0;
            end
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt    <= '0;
            wr_stall_cnt <= '0;
        end else begin
            if (pclk_tick && x_pixel == 10'd0 && y_pixel == 10'd0)
                frame_cnt <= frame_cnt + 16'd1;
            if (wr_valid && !wr_ready && wr_stall_cnt != 16'hFFFF)
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter; inputs change 1 ns after posedge, outputs sampled on negedge.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pclk_tick, de;
    logic [9:0]  x_pixel, y_pixel;
    logic        wr_valid, wr_ready;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] pix_data;
    logic        pix_valid, sync_err;
`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] frame_cnt, wr_stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset), .pclk_tick(pclk_tick), .de(de),
        .x_pixel(x_pixel), .y_pixel(y_pixel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid), .sync_err(sync_err)
`ifdef VGA_FB_ARB_STATS_EN
        , .frame_cnt(frame_cnt), .wr_stall_cnt(wr_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int nwr;
        logic [16:0] wa;
        logic [15:0] wd;

        reset = 1'b1; pclk_tick = 1'b0; de = 1'b0; x_pixel = '0; y_pixel = '0;
        wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 16'h1111; mem_rdata = '0;

        // reset state, writer request must not reach the RAM
        smp();
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_sync_err", sync_err, 0);
        nxt();

        // SYNC: writer always granted
        reset = 1'b0; wr_addr = 17'd10; wr_data = 16'hABCD;
        smp();
        chk("sync_wr_ready", wr_ready, 1);
        chk("sync_mem_we", mem_we, 1);
        chk("sync_mem_addr", mem_addr, 10);
        chk("sync_mem_wdata", mem_wdata, 16'hABCD);
        nxt();
        wr_valid = 1'b0;

        // first tick T: de=1, x=2, y=2 -> buffer (1,1) -> 321
        pclk_tick = 1'b1; de = 1'b1; x_pixel = 10'd2; y_pixel = 10'd2;
        smp();
        chk("T0_mem_en", mem_en, 0);
        nxt();
        pclk_tick = 1'b0;
        smp();
        chk("T1_mem_en", mem_en, 1);
        chk("T1_mem_we", mem_we, 0);
        chk("T1_mem_addr", mem_addr, 321);
        chk("T1_wr_ready", wr_ready, 0);
        nxt();
        mem_rdata = 16'hF800;
        smp();
        chk("T2_mem_en", mem_en, 0);
        chk("T2_pix_valid", pix_valid, 0);
        nxt();
        mem_rdata = 16'h0000;
        smp();
        chk("T3_pix_data", pix_data, 16'hF800);
        chk("T3_pix_valid", pix_valid, 1);
        nxt();

        // blanking tick: no read, writer granted in all phases
        pclk_tick = 1'b1; de = 1'b0; x_pixel = 10'd0; y_pixel = 10'd0; mem_rdata = 16'h1234;
        for (int c = 0; c < 4; c++) begin
            smp();
            chk($sformatf("blank_wr_ready%0d", c), wr_ready, 1);
            chk($sformatf("blank_mem_en%0d", c), mem_en, 0);
            if (c == 3) begin
                chk("blank_pix_data", pix_data, 0);
                chk("blank_pix_valid", pix_valid, 0);
                chk("blank_sync_err", sync_err, 0);
            end
            nxt();
            pclk_tick = 1'b0;
        end

        // continuous writer during active video: phase-1 cycles go to the display
        nwr = 0; wa = 17'd100; wd = 16'h0100; mem_rdata = '0;
        for (int c = 0; c < 8; c++) begin
            pclk_tick = (c % 4 == 0); de = 1'b1; x_pixel = 10'd4; y_pixel = 10'd0;
            wr_valid = 1'b1; wr_addr = wa; wr_data = wd;
            smp();
            if (mem_we) nwr++;
            if (c % 4 == 1) begin
                chk($sformatf("act_rdy%0d", c), wr_ready, 0);
                chk($sformatf("act_rd_addr%0d", c), mem_addr, 2);
                chk($sformatf("act_rd_we%0d", c), mem_we, 0);
            end else begin
                chk($sformatf("act_rdy%0d", c), wr_ready, 1);
                chk($sformatf("act_wr_addr%0d", c), mem_addr, wa);
                chk($sformatf("act_wr_data%0d", c), mem_wdata, wd);
                wa = wa + 17'd1;
                wd = wd + 16'd3;
            end
            nxt();
        end
        chk("act_write_count", nwr, 6);
`ifdef VGA_FB_ARB_STATS_EN
        chk("stats_stall", wr_stall_cnt, 2);
        chk("stats_frame", frame_cnt, 1);
`endif

        // boundary writes
        pclk_tick = 1'b0; wr_addr = 17'd76799; wr_data = 16'h5A5A;
        smp();
        chk("last_wr_ready", wr_ready, 1);
        chk("last_mem_en", mem_en, 1);
        chk("last_mem_we", mem_we, 1);
        chk("last_mem_addr", mem_addr, 76799);
        nxt();
        wr_addr = 17'd76800;
        smp();
        chk("oor_wr_ready", wr_ready, 1);
        chk("oor_mem_en", mem_en, 0);
        chk("oor_mem_we", mem_we, 0);
        chk("oor_sync_err", sync_err, 0);
        nxt();
        wr_valid = 1'b0;

        // out-of-phase tick: B then B+2
        pclk_tick = 1'b1; de = 1'b1; x_pixel = 10'd0; y_pixel = 10'd4;
        nxt();
        pclk_tick = 1'b0;
        smp();
        chk("B1_mem_addr", mem_addr, 640);
        chk("B1_mem_en", mem_en, 1);
        nxt();
        pclk_tick = 1'b1; x_pixel = 10'd6; y_pixel = 10'd0; mem_rdata = 16'h07E0;
        smp();
        chk("B2_sync_err", sync_err, 0);
        nxt();
        pclk_tick = 1'b0;
        smp();
        chk("B3_sync_err", sync_err, 1);
        chk("B3_mem_en", mem_en, 1);
        chk("B3_mem_addr", mem_addr, 3);
        nxt();
        nxt();
        smp();
        chk("B5_pix_data", pix_data, 16'h07E0);
        chk("B5_pix_valid", pix_valid, 1);
        chk("B5_sync_err_sticky", sync_err, 1);
        nxt();

        // reset during a display read
        pclk_tick = 1'b1; x_pixel = 10'd0; y_pixel = 10'd0;
        nxt();
        pclk_tick = 1'b0; reset = 1'b1;
        smp();
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_pix_data", pix_data, 0);
        chk("mid_rst_sync_err", sync_err, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        nxt();
        reset = 1'b0;
        nxt();
        nxt();
        nxt();
        smp();
        chk("post_rst_pix_valid", pix_valid, 0);
        chk("post_rst_wr_ready", wr_ready, 1);
        chk("post_rst_mem_en", mem_en, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
